// File: rtl/cache_request_arbiter_pkg.sv
// Shared definitions for the cache request arbiter: FSM state encoding,
// client identifiers and the starvation counter width.
package cache_request_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_ACK   = 2'd3
   } arb_state_t;

   typedef enum logic {
      CLIENT_DISP = 1'b0,
      CLIENT_CPU  = 1'b1
   } client_t;

   localparam int STARVE_W = 4;

endpackage

// File: rtl/cache_request_arbiter_priority_select.sv
// Grant decision between display and CPU: display wins ties unless the CPU
// has been passed over STARVE_LIMIT times in a row.
module arb_priority_select
   import cache_request_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic    clock,
   input  logic    reset,
   input  logic    d_req,
   input  logic    c_req,
   input  logic    arb_en,
   output logic    grant_valid,
   output client_t grant
);

   logic [STARVE_W-1:0] starve_ctr;
   logic                starved;

   assign starved     = (starve_ctr == STARVE_W'(STARVE_LIMIT));
   assign grant_valid = d_req | c_req;

   always_comb begin
      grant = CLIENT_DISP;
      if (c_req && (!d_req || starved)) begin
         grant = CLIENT_CPU;
      end
   end

   // Counts display grants taken while the CPU waits; any CPU grant or an idle CPU clears it.
   always_ff @(posedge clock) begin
      if (reset) begin
         starve_ctr <= '0;
      end else if (!c_req) begin
         starve_ctr <= '0;
      end else if (arb_en && grant_valid) begin
         if (grant == CLIENT_CPU) begin
            starve_ctr <= '0;
         end else if (!starved) begin
            starve_ctr <= starve_ctr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cache_request_arbiter.sv
// Two-client arbiter in front of the byte cache: one transaction at a time on
// the enable/busy interface, with a one-cycle ack and read data per client.
module cache_request_arbiter
   import cache_request_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 24
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_bypass,
   output logic              d_ack,
   output logic [7:0]        d_rdata,
   input  logic              c_req,
   input  logic              c_write,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [7:0]        c_wdata,
   input  logic              c_bypass,
   input  logic              c_combine,
   output logic              c_ack,
   output logic [7:0]        c_rdata,
   output logic              cache_enable,
   output logic [ADDR_W-1:0] cache_address,
   output logic [7:0]        cache_data_in,
   output logic              cache_read,
   output logic              cache_read_en,
   output logic              cache_write_en,
   output logic              cache_bypass,
   output logic              cache_combine,
   input  logic              cache_busy,
   input  logic [7:0]        cache_data_out,
   output logic              owner
);

   arb_state_t        state, next_state;
   client_t           owner_q, grant;
   logic              grant_valid;
   logic              start, done;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q;
   logic [7:0]        d_rdata_q, c_rdata_q;
   logic              read_q, bypass_q, combine_q;

   arb_priority_select #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_select (
      .clock       (clock),
      .reset       (reset),
      .d_req       (d_req),
      .c_req       (c_req),
      .arb_en      (state == ARB_IDLE),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   assign start = (state == ARB_IDLE) && grant_valid;
   assign done  = (state == ARB_WAIT) && !cache_busy;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state     = state;
      cache_enable   = 1'b0;
      cache_read_en  = 1'b0;
      cache_write_en = 1'b0;
      d_ack          = 1'b0;
      c_ack          = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (grant_valid) begin
               next_state = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            cache_enable   = 1'b1;
            cache_read_en  = read_q;
            cache_write_en = !read_q;
            next_state     = ARB_WAIT;
         end
         ARB_WAIT: begin
            cache_read_en  = read_q;
            cache_write_en = !read_q;
            // The cache raises busy on the enable edge, so low here always means finished.
            if (!cache_busy) begin
               next_state = ARB_ACK;
            end
         end
         ARB_ACK: begin
            d_ack      = (owner_q == CLIENT_DISP);
            c_ack      = (owner_q == CLIENT_CPU);
            next_state = ARB_IDLE;
         end
         default: next_state = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         owner_q   <= CLIENT_DISP;
         addr_q    <= '0;
         wdata_q   <= '0;
         read_q    <= 1'b0;
         bypass_q  <= 1'b0;
         combine_q <= 1'b0;
         d_rdata_q <= '0;
         c_rdata_q <= '0;
      end else begin
         if (start) begin
            owner_q <= grant;
            if (grant == CLIENT_CPU) begin
               addr_q    <= c_addr;
               wdata_q   <= c_wdata;
               read_q    <= !c_write;
               bypass_q  <= c_bypass;
               combine_q <= c_combine;
            end else begin
               addr_q    <= d_addr;
               wdata_q   <= '0;
               read_q    <= 1'b1;
               bypass_q  <= d_bypass;
               combine_q <= 1'b0;
            end
         end
         // Only reads update the returned byte; a write ack leaves rdata as it was.
         if (done && read_q) begin
            if (owner_q == CLIENT_CPU) begin
               c_rdata_q <= cache_data_out;
            end else begin
               d_rdata_q <= cache_data_out;
            end
         end
      end
   end

   assign cache_address = addr_q;
   assign cache_data_in = wdata_q;
   assign cache_read    = read_q;
   assign cache_bypass  = bypass_q;
   assign cache_combine = combine_q;
   assign d_rdata       = d_rdata_q;
   assign c_rdata       = c_rdata_q;
   assign owner         = owner_q;

endmodule

// File: tb/tb_cache_request_arbiter.sv
// Directed and randomized bench for cache_request_arbiter with a transaction-level
// reference model and a behavioural busy/data cache model.
module tb_cache_request_arbiter;
   import cache_request_arbiter_pkg::*;

   localparam int STARVE_LIMIT = 4;
   localparam int ADDR_W       = 24;

   logic              clock = 1'b0;
   logic              reset;
   logic              d_req, d_bypass, d_ack;
   logic [ADDR_W-1:0] d_addr;
   logic [7:0]        d_rdata;
   logic              c_req, c_write, c_bypass, c_combine, c_ack;
   logic [ADDR_W-1:0] c_addr;
   logic [7:0]        c_wdata, c_rdata;
   logic              cache_enable, cache_read, cache_read_en, cache_write_en;
   logic              cache_bypass, cache_combine, cache_busy, owner;
   logic [ADDR_W-1:0] cache_address;
   logic [7:0]        cache_data_in, cache_data_out;

   cache_request_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .ADDR_W       (ADDR_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .d_req          (d_req),
      .d_addr         (d_addr),
      .d_bypass       (d_bypass),
      .d_ack          (d_ack),
      .d_rdata        (d_rdata),
      .c_req          (c_req),
      .c_write        (c_write),
      .c_addr         (c_addr),
      .c_wdata        (c_wdata),
      .c_bypass       (c_bypass),
      .c_combine      (c_combine),
      .c_ack          (c_ack),
      .c_rdata        (c_rdata),
      .cache_enable   (cache_enable),
      .cache_address  (cache_address),
      .cache_data_in  (cache_data_in),
      .cache_read     (cache_read),
      .cache_read_en  (cache_read_en),
      .cache_write_en (cache_write_en),
      .cache_bypass   (cache_bypass),
      .cache_combine  (cache_combine),
      .cache_busy     (cache_busy),
      .cache_data_out (cache_data_out),
      .owner          (owner)
   );

   always #5 clock = ~clock;

   int          checks, errors, cyc;
   logic        m_busy, m_idle, rearm;
   int          m_ack_at, starve;
   client_t     m_owner;
   logic [23:0] m_addr;
   logic [7:0]  m_wdata, exp_drd, exp_crd;
   logic        m_read, m_bypass, m_combine;
   int          next_lat, fix_lat;
   logic        fix_en;
   logic [7:0]  fix_val;
   logic [3:0]  busy_cnt;
   int          en_cyc, ack_cyc, n_grants;
   logic [9:0]  seq;
   logic        hold_d, hold_c, rand_mode, chk_starve0;

   function automatic logic [7:0] exp_data(input logic [23:0] a);
      if (fix_en) return fix_val;
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
   endfunction

   // Cache: busy for next_lat cycles after enable, except a combined low-byte write.
   always @(posedge clock) begin
      if (reset) begin
         busy_cnt       <= '0;
         cache_data_out <= '0;
      end else if (cache_enable) begin
         if (cache_combine && !cache_read && !cache_address[0]) busy_cnt <= '0;
         else busy_cnt <= 4'(next_lat);
         cache_data_out <= exp_data(cache_address);
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 4'd1;
      end
   end
   assign cache_busy = (busy_cnt != 0);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic rand_d();
      d_req    = 1'b1;
      d_addr   = 24'($urandom);
      d_bypass = 1'($urandom_range(0, 1));
   endtask

   task automatic rand_c();
      c_req     = 1'b1;
      c_write   = 1'($urandom_range(0, 1));
      c_addr    = 24'($urandom);
      c_wdata   = 8'($urandom);
      c_bypass  = 1'($urandom_range(0, 1));
      c_combine = c_bypass & c_write & 1'($urandom_range(0, 1));
   endtask

   task automatic tick();
      logic    exp_en, ack_now, lowcomb, in_txn;
      client_t win;
      @(negedge clock);
      cyc++;
      exp_en  = 1'b0;
      ack_now = 1'b0;
      if (reset) begin
         m_busy = 0; m_idle = 1; rearm = 0; starve = 0;
         m_owner = CLIENT_DISP; m_addr = '0; m_wdata = '0;
         m_read = 0; m_bypass = 0; m_combine = 0; exp_drd = '0; exp_crd = '0;
      end else begin
         exp_en = m_idle && (d_req || c_req);
         if (exp_en) begin
            if (d_req && c_req) win = (starve == STARVE_LIMIT) ? CLIENT_CPU : CLIENT_DISP;
            else win = c_req ? CLIENT_CPU : CLIENT_DISP;
            m_owner = win;
            if (win == CLIENT_CPU) begin
               m_addr = c_addr; m_wdata = c_wdata; m_read = !c_write;
               m_bypass = c_bypass; m_combine = c_combine;
            end else begin
               m_addr = d_addr; m_wdata = '0; m_read = 1'b1;
               m_bypass = d_bypass; m_combine = 1'b0;
            end
            next_lat = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 4));
            lowcomb  = (win == CLIENT_CPU) && c_combine && c_write && !c_addr[0];
            m_ack_at = cyc + (lowcomb ? 2 : next_lat + 2);
            m_busy   = 1'b1;
            if (!c_req || win == CLIENT_CPU) starve = 0;
            else if (starve < STARVE_LIMIT) starve++;
         end else if (!c_req) begin
            starve = 0;
         end
         ack_now = m_busy && (cyc == m_ack_at);
         if (ack_now && m_read) begin
            if (m_owner == CLIENT_CPU) exp_crd = exp_data(m_addr);
            else exp_drd = exp_data(m_addr);
         end
      end
      in_txn = m_busy && !ack_now;
      chk("cache_enable", cache_enable, exp_en);
      chk("d_ack", d_ack, ack_now && m_owner == CLIENT_DISP);
      chk("c_ack", c_ack, ack_now && m_owner == CLIENT_CPU);
      chk("cache_read_en", cache_read_en, in_txn && m_read);
      chk("cache_write_en", cache_write_en, in_txn && !m_read);
      chk("owner", owner, m_owner);
      chk("cache_address", cache_address, m_addr);
      chk("cache_data_in", cache_data_in, m_wdata);
      chk("cache_read", cache_read, m_read);
      chk("cache_bypass", cache_bypass, m_bypass);
      chk("cache_combine", cache_combine, m_combine);
      chk("d_rdata", d_rdata, exp_drd);
      chk("c_rdata", c_rdata, exp_crd);
      if (chk_starve0) chk("starve_ctr_zero", dut.u_select.starve_ctr, 0);
      if (!reset) begin
         if (exp_en) m_idle = 1'b0;
         if (rearm) begin m_idle = 1'b1; rearm = 1'b0; end
         if (ack_now) begin rearm = 1'b1; m_busy = 1'b0; end
      end
      if (cache_enable) begin
         en_cyc = cyc;
         seq    = {seq[8:0], owner};
         n_grants++;
      end
      if (d_ack || c_ack) ack_cyc = cyc;
      if (d_ack) begin
         if (hold_d || (rand_mode && $urandom_range(0, 1) == 1)) rand_d();
         else d_req = 1'b0;
      end
      if (c_ack) begin
         if (hold_c || (rand_mode && $urandom_range(0, 1) == 1)) rand_c();
         else c_req = 1'b0;
      end
      if (rand_mode && !d_req && $urandom_range(0, 3) == 0) rand_d();
      if (rand_mode && !c_req && $urandom_range(0, 3) == 0) rand_c();
   endtask

   task automatic wait_enable(input string tag);
      int n = 0;
      do begin tick(); n++; end while (!cache_enable && n < 20);
      chk({tag, "_enable_seen"}, cache_enable, 1'b1);
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      do begin tick(); n++; end while (!(d_ack || c_ack) && n < 40);
      chk({tag, "_ack_seen"}, d_ack || c_ack, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while ((d_req || c_req || m_busy) && n < 100) begin tick(); n++; end
      chk("drain_idle", d_req || c_req || m_busy, 1'b0);
      tick();
      tick();
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0;
      reset = 1'b1;
      d_req = 0; d_addr = '0; d_bypass = 0;
      c_req = 0; c_write = 0; c_addr = '0; c_wdata = '0; c_bypass = 0; c_combine = 0;
      m_busy = 0; m_idle = 1; rearm = 0; m_ack_at = 0; starve = 0;
      next_lat = 1; fix_lat = 0; fix_en = 0; fix_val = '0;
      en_cyc = 0; ack_cyc = 0; n_grants = 0; seq = '0;
      hold_d = 0; hold_c = 0; rand_mode = 0; chk_starve0 = 0;

      // Reset state
      tick();
      tick();
      chk("reset_state", 32'(dut.state), 32'(ARB_IDLE));
      chk("reset_starve", dut.u_select.starve_ctr, 0);
      reset = 1'b0;
      tick();

      // Display read with a 4-cycle busy returning 0x5A
      fix_lat = 4; fix_en = 1'b1; fix_val = 8'h5A;
      d_addr = 24'h000123; d_bypass = 1'b0; d_req = 1'b1;
      wait_ack("disp_read");
      chk("disp_rdata", d_rdata, 8'h5A);
      chk("disp_ack_latency", ack_cyc - en_cyc, 6);
      fix_en = 1'b0; fix_lat = 0;
      tick();

      // CPU write
      c_write = 1'b1; c_addr = 24'h001000; c_wdata = 8'hC3;
      c_bypass = 1'b0; c_combine = 1'b0; c_req = 1'b1;
      wait_enable("cpu_write");
      chk("cpu_write_data_in", cache_data_in, 8'hC3);
      chk("cpu_write_en", cache_write_en, 1'b1);
      wait_ack("cpu_write");
      chk("cpu_write_rdata_kept", c_rdata, 8'h00);
      tick();

      // Both requesters held: D D D D C D D D D C
      hold_d = 1'b1; hold_c = 1'b1;
      rand_d();
      rand_c();
      seq = '0; n_grants = 0;
      for (int n = 0; n < 300 && n_grants < 10; n++) tick();
      chk("starve_sequence", seq, 10'b0000100001);
      hold_d = 1'b0; hold_c = 1'b0;
      drain();

      // Combined writes: low byte never goes busy, high byte does
      fix_lat = 3;
      c_write = 1'b1; c_bypass = 1'b1; c_combine = 1'b1;
      c_addr = 24'h000200; c_wdata = 8'h11; c_req = 1'b1;
      wait_ack("combine_low");
      chk("combine_low_latency", ack_cyc - en_cyc, 2);
      chk("combine_low_flag", cache_combine, 1'b1);
      tick();
      c_addr = 24'h000201; c_wdata = 8'h22; c_req = 1'b1;
      wait_ack("combine_high");
      chk("combine_high_latency", ack_cyc - en_cyc, 5);
      chk("combine_high_flag", cache_combine, 1'b1);
      tick();
      fix_lat = 0;
      c_combine = 1'b0; c_bypass = 1'b0;

      // Reset during WAIT, then a fresh display request
      d_addr = 24'h00ABCD; d_bypass = 1'b1; d_req = 1'b1;
      wait_enable("pre_reset");
      tick();
      chk("in_wait", 32'(dut.state), 32'(ARB_WAIT));
      reset = 1'b1; d_req = 1'b0; c_req = 1'b0;
      tick();
      chk("mid_reset_state", 32'(dut.state), 32'(ARB_IDLE));
      chk("mid_reset_d_rdata", d_rdata, 8'h00);
      reset = 1'b0;
      tick();
      d_addr = 24'h000456; d_bypass = 1'b0; d_req = 1'b1;
      wait_ack("post_reset");
      tick();

      // CPU alone: the starvation counter never moves
      chk_starve0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         c_write = 1'b0; c_addr = 24'($urandom); c_req = 1'b1;
         wait_ack("cpu_alone");
         tick();
      end
      chk_starve0 = 1'b0;

      // Randomized traffic against the reference model
      rand_mode = 1'b1;
      for (int i = 0; i < 800; i++) tick();
      rand_mode = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
